pc_sequencer: RTL

Fetch-stage sequencer that owns the architectural PC register and drives the next-PC datapath. Each cycle it presents the current PC to the next-PC logic, handshakes with instruction memory, and buffers the fetched word for ID. It arbitrates between the normal next PC, EX-stage branch correction and exception/ERET redirects. It also tolerates downstream stalls and variable-latency memory without losing or duplicating instructions.

---
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-stage bundle: next-PC loop, flush requests, ID stall, instruction memory
// handshake and the buffered output stage.
interface pc_sequencer_if;
    logic [31:0] pc;
    logic [31:0] npc_in;
    logic        spec_valid;
    logic [31:0] spec_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    modport master (
        output pc, imem_req, imem_addr, if_valid, if_pc, if_inst,
        input  npc_in, spec_valid, spec_pc, redirect_valid, redirect_pc, stall,
               imem_ack, imem_rdata
    );

    modport slave (
        input  pc, imem_req, imem_addr, if_valid, if_pc, if_inst,
        output npc_in, spec_valid, spec_pc, redirect_valid, redirect_pc, stall,
               imem_ack, imem_rdata
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, issues instruction fetches, arbitrates flushes and
// buffers fetched words in an output stage backed by a one-entry skid.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {StRst, StReq, StDrop, StHold} state_t;

    state_t      state_q, state_d;
    logic        boot_q, boot_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;

    logic        flush;
    logic [31:0] target;
    logic        consume;

    assign flush   = bus.spec_valid | bus.redirect_valid;
    assign target  = bus.spec_valid ? bus.spec_pc : bus.redirect_pc;
    assign consume = out_valid_q & ~bus.stall;

    always_comb begin
        state_d      = state_q;
        boot_d       = boot_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;

        if (consume) out_valid_d = 1'b0;

        unique case (state_q)
            // boot_q stretches RST over one full cycle after reset release
            StRst: begin
                boot_d = 1'b1;
                if (boot_q) state_d = StReq;
            end
            StReq: begin
                addr_d = pc_q;
                if (bus.imem_ack && !flush) begin
                    pc_d = bus.npc_in;
                    if (!out_valid_q || consume) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = pc_q;
                        out_inst_d  = bus.imem_rdata;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = pc_q;
                        skid_inst_d  = bus.imem_rdata;
                        state_d      = StHold;
                    end
                end else if (flush && !bus.imem_ack) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (bus.imem_ack) state_d = StReq;
            end
            StHold: begin
                if (flush) begin
                    state_d = StReq;
                end else if (consume) begin
                    out_valid_d  = 1'b1;
                    out_pc_d     = skid_pc_q;
                    out_inst_d   = skid_inst_q;
                    skid_valid_d = 1'b0;
                    state_d      = StReq;
                end
            end
            default: state_d = StRst;
        endcase

        // A flush overrides npc_in and empties both buffers, whatever the state.
        if (flush) begin
            pc_d         = target;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRst;
            boot_q       <= 1'b0;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_pc_q     <= 32'h0;
            out_inst_q   <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_inst_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            boot_q       <= boot_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.imem_req  = (state_q == StReq) || (state_q == StDrop);
    assign bus.imem_addr = (state_q == StDrop) ? addr_q : pc_q;
    assign bus.if_valid  = out_valid_q;
    assign bus.if_pc     = out_pc_q;
    assign bus.if_inst   = out_inst_q;

endmodule
